mp_reg_file_sb: RTL and testbench
=================================

// Module: mp_reg_file_sb
// PURPOSE
//  Parametrised multi-port architectural register file with a per-register busy scoreboard.
//  Serves the issue stage of the wider pipeline: RD_PORTS reads, WR_PORTS writebacks.
//  Same-cycle write->read bypass. A post-reset clear sequencer lets the array map to LUTRAM.
//  Register 0 is hard-wired to zero and is never busy.
// PARAMETERS
//  DATA_W    32   register width in bits
//  REG_NUM   32   number of registers (power of 2, >=2)
//  ADDR_W    5    address width, must equal log2(REG_NUM)
//  RD_PORTS  4    number of read ports (1..8)
//  WR_PORTS  2    number of write ports (1..4)
// PORTS
//  mprf_in_clk          in   1                  clock, all state updates on rising edge
//  mprf_in_rstL         in   1                  synchronous reset, active-high (1 = reset)
//  mprf_in_re           in   RD_PORTS           per-port read enable
//  mprf_in_raddr        in   RD_PORTS*ADDR_W    read addresses, port p at [p*ADDR_W +: ADDR_W]
//  mprf_out_rdata       out  RD_PORTS*DATA_W    read data, combinational
//  mprf_out_rbusy       out  RD_PORTS           operand not yet available, combinational
//  mprf_in_we           in   WR_PORTS           per-port write enable
//  mprf_in_waddr        in   WR_PORTS*ADDR_W    write addresses
//  mprf_in_wdata        in   WR_PORTS*DATA_W    write data
//  mprf_in_issue_en     in   1                  set busy on issue_addr (new producer issued)
//  mprf_in_issue_addr   in   ADDR_W             destination register of the issued instruction
//  mprf_out_init_done   out  1                  1 = clear finished, block accepts traffic
//  mprf_out_wr_conflict out  1                  only with MPRF_CONFLICT_FLAG_EN
// BEHAVIOUR
//  FSM states:
//   - CLEAR: entered on any cycle with rstL=1, including mid-operation; clears the index counter.
//     Writes Regs[idx]=0 and busy[idx]=0, one register per cycle.
//     After idx=REG_NUM-1, moves to RUN. Total: REG_NUM cycles after reset deasserts.
//   - RUN: normal operation, init_done=1.
//  Outputs while rstL=1 or in CLEAR: rdata=0, rbusy=0, init_done=0, wr_conflict=0.
//   we/issue_en are ignored in this state.
//  Write:
//   - Takes effect at the next edge; writes to addr 0 are dropped.
//   - Two or more ports writing the same addr: the highest port index wins.
//  Read, port p (priority order):
//   - raddr=0 -> 0.
//   - Else re=1 and a same-cycle enabled write matches -> wdata of the highest matching port.
//   - Else Regs[raddr].
//   - With re=0, data is still driven but no bypass is applied.
//  Scoreboard, RUN only:
//   - Writeback clears busy[waddr] at the next edge.
//   - issue_en sets busy[issue_addr] at the next edge.
//   - Set and clear on the same register in one cycle: set wins (a newer producer is pending).
//   - issue_addr=0 is ignored.
//  rbusy[p] = busy[raddr] & ~(re & bypass hit on raddr) & (raddr!=0). Zero-latency wakeup via bypass.
// CONFIGURATION
//  MPRF_CONFLICT_FLAG_EN defined:
//   - Port mprf_out_wr_conflict exists.
//   - Registered 1-cycle pulse, the cycle after >=2 enabled write ports hit the same nonzero addr.
//   - Reset value 0.
//  MPRF_CONFLICT_FLAG_EN undefined:
//   - Port and detection logic are absent.
//   - Priority resolution is unchanged.
// STRUCTURE
//  Shared define header holds:
//   - RstEnable=1'b1, WriteEnable=1'b1, ReadEnable=1'b1
//   - FSM state encodings MPRF_ST_CLEAR / MPRF_ST_RUN
//   - ZeroWord32B
//  Sub-module mprf_scoreboard:
//   - Busy-bit vector with set/clear priority.
//   - Clear-index input driven by the top-level FSM.
//  Top level holds the array, write-priority mux, bypass network and clear FSM.
// TESTING
//  1. Deassert reset; count cycles -> init_done rises after exactly REG_NUM (32) cycles.
//     During the clear, read r5 -> 0.
//  2. WP0 writes r3=0x11, WP1 writes r3=0x22 in the same cycle; read r3 next cycle -> 0x22.
//     With MPRF_CONFLICT_FLAG_EN, wr_conflict pulses once.
//  3. Same-cycle WP0 r7=0xDEADBEEF with RP2 reading r7 (re=1) -> rdata2=0xDEADBEEF combinationally.
//     With re=0 -> old value.
//  4. Issue r9 -> rbusy=1 next cycle. Writeback r9 in the same cycle as a read -> rbusy=0, data bypassed.
//     Issue r9 plus writeback r9 in the same cycle -> still busy.
//  5. Write r0=0xFFFF and issue r0 -> read r0 gives 0 and rbusy=0.
//  6. Assert reset mid-run after writing r1=0x5 -> CLEAR restarts, init_done=0.
//     After 32 cycles, r1 reads 0 and is not busy.

Source files
------------

// File: rtl/mp_reg_file_sb_pkg.sv
// Shared constants and FSM state encodings for the multi-port register file
// and its busy scoreboard.
package mp_reg_file_sb_pkg;

    localparam logic        RstEnable   = 1'b1;
    localparam logic        WriteEnable = 1'b1;
    localparam logic        ReadEnable  = 1'b1;
    localparam logic [31:0] ZeroWord32B = 32'h0000_0000;

    typedef enum logic {
        MPRF_ST_CLEAR = 1'b0,
        MPRF_ST_RUN   = 1'b1
    } mprf_state_e;

endpackage

// File: rtl/mprf_scoreboard.sv
// Per-register busy bits. The clear sequencer zeroes one bit per cycle.
// Within a cycle a new issue overrides a writeback to the same register.
module mprf_scoreboard
    import mp_reg_file_sb_pkg::*;
#(
    parameter int REG_NUM  = 32,
    parameter int ADDR_W   = 5,
    parameter int WR_PORTS = 2
) (
    input  logic                         clk,
    input  logic                         srst,
    input  logic                         clear_en,
    input  logic [ADDR_W-1:0]            clear_idx,
    input  logic [WR_PORTS-1:0]          wb_en,
    input  logic [WR_PORTS*ADDR_W-1:0]   wb_addr,
    input  logic                         issue_en,
    input  logic [ADDR_W-1:0]            issue_addr,
    output logic [REG_NUM-1:0]           busy
);

    logic [REG_NUM-1:0] busy_reg;
    logic [REG_NUM-1:0] busy_next;

    always_comb begin
        busy_next = busy_reg;
        if (clear_en) begin
            busy_next[clear_idx] = 1'b0;
        end else begin
            for (int w = 0; w < WR_PORTS; w++) begin
                if (wb_en[w]) begin
                    busy_next[wb_addr[w*ADDR_W +: ADDR_W]] = 1'b0;
                end
            end
            // Applied after the clears so a newer producer stays pending.
            if (issue_en && (issue_addr != '0)) begin
                busy_next[issue_addr] = 1'b1;
            end
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (srst == RstEnable) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign busy = busy_reg;

endmodule

// File: rtl/mp_reg_file_sb.sv
// Multi-port register file with write->read bypass, busy scoreboard and a
// post-reset clear sequencer. Optional macro: MPRF_CONFLICT_FLAG_EN.
module mp_reg_file_sb
    import mp_reg_file_sb_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_NUM  = 32,
    parameter int ADDR_W   = 5,
    parameter int RD_PORTS = 4,
    parameter int WR_PORTS = 2
) (
    input  logic                         mprf_in_clk,
    input  logic                         mprf_in_rstL,
    input  logic [RD_PORTS-1:0]          mprf_in_re,
    input  logic [RD_PORTS*ADDR_W-1:0]   mprf_in_raddr,
    output logic [RD_PORTS*DATA_W-1:0]   mprf_out_rdata,
    output logic [RD_PORTS-1:0]          mprf_out_rbusy,
    input  logic [WR_PORTS-1:0]          mprf_in_we,
    input  logic [WR_PORTS*ADDR_W-1:0]   mprf_in_waddr,
    input  logic [WR_PORTS*DATA_W-1:0]   mprf_in_wdata,
    input  logic                         mprf_in_issue_en,
    input  logic [ADDR_W-1:0]            mprf_in_issue_addr,
    output logic                         mprf_out_init_done
`ifdef MPRF_CONFLICT_FLAG_EN
    ,
    output logic                         mprf_out_wr_conflict
`endif
);

    logic                rst;
    logic                run;
    logic                clearing;
    mprf_state_e         state_reg;
    mprf_state_e         state_next;
    logic [ADDR_W-1:0]   clr_idx_reg;
    logic [ADDR_W-1:0]   clr_idx_next;
    logic [WR_PORTS-1:0] we_run;
    logic [ADDR_W-1:0]   waddr_a [WR_PORTS];
    logic [DATA_W-1:0]   wdata_a [WR_PORTS];
    logic [DATA_W-1:0]   regs_reg [REG_NUM];
    logic [REG_NUM-1:0]  busy;

    assign rst      = (mprf_in_rstL == RstEnable);
    assign run      = (state_reg == MPRF_ST_RUN) && !rst;
    assign clearing = (state_reg == MPRF_ST_CLEAR) && !rst;
    assign mprf_out_init_done = run;

    always_ff @(posedge mprf_in_clk) begin
        if (rst) begin
            state_reg   <= MPRF_ST_CLEAR;
            clr_idx_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_idx_reg <= clr_idx_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clr_idx_next = clr_idx_reg;
        case (state_reg)
            MPRF_ST_CLEAR: begin
                clr_idx_next = clr_idx_reg + ADDR_W'(1);
                if (clr_idx_reg == ADDR_W'(REG_NUM - 1)) begin
                    state_next = MPRF_ST_RUN;
                end
            end
            default: state_next = MPRF_ST_RUN;
        endcase
    end

    generate
        for (genvar gi = 0; gi < WR_PORTS; gi++) begin : g_wr
            assign waddr_a[gi] = mprf_in_waddr[gi*ADDR_W +: ADDR_W];
            assign wdata_a[gi] = mprf_in_wdata[gi*DATA_W +: DATA_W];
            assign we_run[gi]  = run && (mprf_in_we[gi] == WriteEnable);
        end
    endgenerate

    // No reset on the array: the clear sequencer zeroes it so it can map to LUTRAM.
    always_ff @(posedge mprf_in_clk) begin
        if (clearing) begin
            regs_reg[clr_idx_reg] <= DATA_W'(ZeroWord32B);
        end else begin
            for (int w = 0; w < WR_PORTS; w++) begin
                if (we_run[w] && (waddr_a[w] != '0)) begin
                    regs_reg[waddr_a[w]] <= wdata_a[w];
                end
            end
        end
    end

    mprf_scoreboard #(
        .REG_NUM  (REG_NUM),
        .ADDR_W   (ADDR_W),
        .WR_PORTS (WR_PORTS)
    ) u_scoreboard (
        .clk        (mprf_in_clk),
        .srst       (mprf_in_rstL),
        .clear_en   (clearing),
        .clear_idx  (clr_idx_reg),
        .wb_en      (we_run),
        .wb_addr    (mprf_in_waddr),
        .issue_en   (run && mprf_in_issue_en),
        .issue_addr (mprf_in_issue_addr),
        .busy       (busy)
    );

    generate
        for (genvar gi = 0; gi < RD_PORTS; gi++) begin : g_rd
            logic [ADDR_W-1:0] ra;
            logic              hit;
            logic [DATA_W-1:0] byp;
            logic [DATA_W-1:0] rdata_p;
            logic              rbusy_p;

            assign ra = mprf_in_raddr[gi*ADDR_W +: ADDR_W];

            always_comb begin
                hit     = 1'b0;
                byp     = '0;
                rdata_p = '0;
                rbusy_p = 1'b0;
                if (mprf_in_re[gi] == ReadEnable) begin
                    for (int w = 0; w < WR_PORTS; w++) begin
                        if (we_run[w] && (waddr_a[w] == ra)) begin
                            hit = 1'b1;
                            byp = wdata_a[w];
                        end
                    end
                end
                if (run && (ra != '0)) begin
                    rdata_p = hit ? byp : regs_reg[ra];
                    rbusy_p = busy[ra] & ~hit;
                end
            end

            assign mprf_out_rdata[gi*DATA_W +: DATA_W] = rdata_p;
            assign mprf_out_rbusy[gi]                  = rbusy_p;
        end
    endgenerate

`ifdef MPRF_CONFLICT_FLAG_EN
    logic conflict_reg;
    logic conflict_next;

    always_comb begin
        conflict_next = 1'b0;
        for (int i = 0; i < WR_PORTS; i++) begin
            for (int j = i + 1; j < WR_PORTS; j++) begin
                if (we_run[i] && we_run[j] && (waddr_a[i] == waddr_a[j]) &&
                    (waddr_a[i] != '0)) begin
                    conflict_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge mprf_in_clk) begin
        if (rst) begin
            conflict_reg <= 1'b0;
        end else begin
            conflict_reg <= conflict_next;
        end
    end

    assign mprf_out_wr_conflict = conflict_reg;
`endif

endmodule

// File: tb/tb_mp_reg_file_sb.sv
// Bench for mp_reg_file_sb: directed scenarios plus a per-cycle reference model.
module tb_mp_reg_file_sb;

    localparam int DATA_W   = 32;
    localparam int REG_NUM  = 32;
    localparam int ADDR_W   = 5;
    localparam int RD_PORTS = 4;
    localparam int WR_PORTS = 2;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [RD_PORTS-1:0]        re;
    logic [RD_PORTS*ADDR_W-1:0] raddr;
    logic [RD_PORTS*DATA_W-1:0] rdata;
    logic [RD_PORTS-1:0]        rbusy;
    logic [WR_PORTS-1:0]        we;
    logic [WR_PORTS*ADDR_W-1:0] waddr;
    logic [WR_PORTS*DATA_W-1:0] wdata;
    logic                       issue_en;
    logic [ADDR_W-1:0]          issue_addr;
    logic                       init_done;
`ifdef MPRF_CONFLICT_FLAG_EN
    logic                       wr_conflict;
`endif

    always #5 clk = ~clk;

    mp_reg_file_sb #(
        .DATA_W(DATA_W), .REG_NUM(REG_NUM), .ADDR_W(ADDR_W),
        .RD_PORTS(RD_PORTS), .WR_PORTS(WR_PORTS)
    ) dut (
        .mprf_in_clk          (clk),
        .mprf_in_rstL         (rst),
        .mprf_in_re           (re),
        .mprf_in_raddr        (raddr),
        .mprf_out_rdata       (rdata),
        .mprf_out_rbusy       (rbusy),
        .mprf_in_we           (we),
        .mprf_in_waddr        (waddr),
        .mprf_in_wdata        (wdata),
        .mprf_in_issue_en     (issue_en),
        .mprf_in_issue_addr   (issue_addr),
        .mprf_out_init_done   (init_done)
`ifdef MPRF_CONFLICT_FLAG_EN
        ,
        .mprf_out_wr_conflict (wr_conflict)
`endif
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [DATA_W-1:0] rd(input int p);
        return rdata[p*DATA_W +: DATA_W];
    endfunction

    // Reference model: register contents, pending producers, clear progress.
    logic [DATA_W-1:0] m_regs [REG_NUM];
    bit                m_busy [REG_NUM];
    bit                m_ready = 1'b0;
    int                m_cnt   = 0;
    bit                m_conf  = 1'b0;
    bit                m_run;
    logic [DATA_W-1:0] e_data;
    bit                e_busy;
    bit                e_hit;
    int                a_r;

    always @(negedge clk) begin
        m_run = m_ready && !rst;
        check("init_done_cyc", init_done, m_run);
        for (int p = 0; p < RD_PORTS; p++) begin
            a_r    = int'(raddr[p*ADDR_W +: ADDR_W]);
            e_data = '0;
            e_busy = 1'b0;
            e_hit  = 1'b0;
            if (m_run && a_r != 0) begin
                e_data = m_regs[a_r];
                if (re[p]) begin
                    for (int w = 0; w < WR_PORTS; w++) begin
                        if (we[w] && int'(waddr[w*ADDR_W +: ADDR_W]) == a_r) begin
                            e_hit  = 1'b1;
                            e_data = wdata[w*DATA_W +: DATA_W];
                        end
                    end
                end
                e_busy = m_busy[a_r] && !e_hit;
            end
            check($sformatf("rdata%0d_cyc", p), rd(p), e_data);
            check($sformatf("rbusy%0d_cyc", p), rbusy[p], e_busy);
        end
`ifdef MPRF_CONFLICT_FLAG_EN
        check("wr_conflict_cyc", wr_conflict, m_conf);
`endif
        // Advance the model across the coming rising edge.
        if (rst) begin
            m_ready = 1'b0;
            m_cnt   = 0;
            m_conf  = 1'b0;
        end else if (!m_ready) begin
            m_cnt++;
            m_conf = 1'b0;
            if (m_cnt == REG_NUM) begin
                for (int r = 0; r < REG_NUM; r++) begin
                    m_regs[r] = '0;
                    m_busy[r] = 1'b0;
                end
                m_ready = 1'b1;
            end
        end else begin
            m_conf = we[0] && we[1] && (waddr[0 +: ADDR_W] == waddr[ADDR_W +: ADDR_W]) &&
                     (waddr[0 +: ADDR_W] != 0);
            for (int w = 0; w < WR_PORTS; w++) begin
                if (we[w]) begin
                    a_r = int'(waddr[w*ADDR_W +: ADDR_W]);
                    if (a_r != 0) m_regs[a_r] = wdata[w*DATA_W +: DATA_W];
                    m_busy[a_r] = 1'b0;
                end
            end
            if (issue_en && issue_addr != 0) m_busy[int'(issue_addr)] = 1'b1;
            m_busy[0] = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we       = '0;
        issue_en = 1'b0;
    endtask

    task automatic set_wr(input int w, input int a, input logic [DATA_W-1:0] d);
        we[w]                       = 1'b1;
        waddr[w*ADDR_W +: ADDR_W]   = ADDR_W'(a);
        wdata[w*DATA_W +: DATA_W]   = d;
    endtask

    task automatic set_rd(input int p, input int a, input logic en);
        raddr[p*ADDR_W +: ADDR_W] = ADDR_W'(a);
        re[p]                     = en;
    endtask

    task automatic issue(input int a);
        issue_en   = 1'b1;
        issue_addr = ADDR_W'(a);
    endtask

    task automatic wait_init(input string name, input bit probe_r5);
        int cyc;
        cyc = 0;
        while (init_done !== 1'b1 && cyc < 100) begin
            step();
            cyc++;
            if (probe_r5 && cyc == 3) check("clear_read_r5", rd(0), 0);
        end
        check(name, cyc, REG_NUM);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; re = '0; raddr = '0; we = '0; waddr = '0; wdata = '0;
        issue_en = 1'b0; issue_addr = '0;
        repeat (3) step();
        check("reset_init_done", init_done, 0);
        check("reset_rdata0", rd(0), 0);
        check("reset_rbusy", rbusy, 0);

        // Clear sequence length, with a read issued mid-clear.
        set_rd(0, 5, 1'b1);
        rst = 1'b0;
        wait_init("clear_cycles", 1'b1);

        // Two ports to the same register: highest index wins.
        set_wr(0, 3, 32'h11);
        set_wr(1, 3, 32'h22);
        step();
        idle();
`ifdef MPRF_CONFLICT_FLAG_EN
        check("wr_conflict_pulse", wr_conflict, 1);
`endif
        set_rd(0, 3, 1'b1);
        #1 check("wr_priority_r3", rd(0), 32'h22);
        step();
`ifdef MPRF_CONFLICT_FLAG_EN
        check("wr_conflict_end", wr_conflict, 0);
`endif

        // Same-cycle bypass, and no bypass when re=0.
        set_wr(0, 7, 32'h1234);
        step();
        idle();
        set_wr(0, 7, 32'hDEADBEEF);
        set_rd(2, 7, 1'b1);
        #1 check("bypass_r7", rd(2), 32'hDEADBEEF);
        re[2] = 1'b0;
        #1 check("no_bypass_r7", rd(2), 32'h1234);
        step();
        idle();
        set_rd(2, 7, 1'b1);
        #1 check("commit_r7", rd(2), 32'hDEADBEEF);

        // Scoreboard: issue, bypass wakeup, issue+writeback collision.
        issue(9);
        step();
        idle();
        set_rd(1, 9, 1'b1);
        #1 check("issue_busy_r9", rbusy[1], 1);
        set_wr(0, 9, 32'hABC);
        #1 check("wakeup_rbusy_r9", rbusy[1], 0);
        check("wakeup_rdata_r9", rd(1), 32'hABC);
        step();
        idle();
        #1 check("after_wb_busy_r9", rbusy[1], 0);
        issue(9);
        set_wr(1, 9, 32'h55);
        step();
        idle();
        #1 check("set_wins_busy_r9", rbusy[1], 1);
        check("set_wins_data_r9", rd(1), 32'h55);

        // Register zero: writes and issues are dropped.
        set_wr(0, 0, 32'hFFFF);
        issue(0);
        set_rd(3, 0, 1'b1);
        #1 check("r0_bypass_data", rd(3), 0);
        check("r0_bypass_busy", rbusy[3], 0);
        step();
        idle();
        #1 check("r0_data", rd(3), 0);
        check("r0_busy", rbusy[3], 0);

        // Mid-run reset restarts the clear.
        set_wr(0, 1, 32'h5);
        issue(1);
        step();
        idle();
        set_rd(0, 1, 1'b1);
        #1 check("r1_before_reset", rd(0), 32'h5);
        check("r1_busy_before_reset", rbusy[0], 1);
        rst = 1'b1;
        #1 check("midrun_reset_init_done", init_done, 0);
        check("midrun_reset_rdata", rd(0), 0);
        step();
        step();
        rst = 1'b0;
        wait_init("reclear_cycles", 1'b0);
        #1 check("r1_after_clear", rd(0), 0);
        check("r1_busy_after_clear", rbusy[0], 0);

        repeat (2) step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
